// File: rtl/gpio_ctrl_apb_master.sv
// APB4 requester: turns single-beat valid/ready commands into APB transfers toward
// the GPIO controller CSR space and returns read data / error on a response channel.
module gpio_ctrl_apb_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  // command channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB requester port
  output logic [9:0]  paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          timeout_hit;

  // NOTE: psel/penable/req_ready/rsp_valid decode straight from state, so the
  // async reset drops the bus select immediately instead of at the next edge.
  assign req_ready   = (state == IDLE);
  assign psel        = (state == SETUP) || (state == ACCESS);
  assign penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign accept      = req_valid && req_ready;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  if (pready || timeout_hit) state <= RESP;
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Command registers double as the APB address/data phase; reads carry no strobes or data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pstrb  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      paddr  <= req_addr;
      pwrite <= req_write;
      pstrb  <= req_write ? req_strb  : 4'h0;
      pwdata <= req_write ? req_wdata : 32'h0;
    end
  end

  // Wait counter saturates so a disabled timeout never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready && !timeout_hit && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // pready wins over a coincident timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (state == ACCESS) begin
      if (pready) begin
        rsp_rdata   <= pwrite ? 32'h0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata   <= 32'h0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
